// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the execute-stage M-extension unit:
//   - XLEN            : architectural register width
//   - AC_* codes      : arith_control values for the RV32M operations
//   - md_state_t      : multiply/divide sequencer states
//   - is_md_op()      : true when an arith_control code is an M-extension op
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] AC_MUL    = 5'd16;
    localparam logic [4:0] AC_MULH   = 5'd17;
    localparam logic [4:0] AC_MULHSU = 5'd18;
    localparam logic [4:0] AC_MULHU  = 5'd19;
    localparam logic [4:0] AC_DIV    = 5'd20;
    localparam logic [4:0] AC_DIVU   = 5'd21;
    localparam logic [4:0] AC_REM    = 5'd22;
    localparam logic [4:0] AC_REMU   = 5'd23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FAST = 2'd2,
        DONE = 2'd3
    } md_state_t;

    function automatic logic is_md_op(input logic [4:0] code);
        return (code >= AC_MUL) && (code <= AC_REMU);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// ---------------------------------------------------------------------------
// muldiv_datapath
// Operand/accumulator registers for the iterative multiply/divide unit.
// Multiply is a radix-2 shift-add over {hi, lo}; divide is restoring
// division with hi = partial remainder and lo = dividend/quotient.
// Operands are held as magnitudes; signs are re-applied on the final step.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load         latch a new normal operation (magnitudes, sign flags)
//   fast_load    latch the special-case result (divide by zero / overflow)
//   step         perform one iteration
//   last         current step is the final one; capture the fixed-up result
//   commit       move the preloaded special-case result to result
//   op           arith_control code (sampled on load/fast_load)
//   src_a, src_b forwarded operands
//   result       registered result, held until the next capture
// ---------------------------------------------------------------------------
module muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            fast_load,
    input  logic            step,
    input  logic            last,
    input  logic            commit,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] result
);
    import riscv_pkg::*;

    logic [XLEN-1:0] hi, lo, mcand, result_q;
    logic            is_div_q, hi_word_q, want_rem_q, neg_q, neg_r;

    logic            op_is_div, sa_signed, sb_signed, sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] hi_n, lo_n;
    logic [XLEN:0]   sum, shifted;
    logic [XLEN+1:0] diff;

    // Result for the cases that bypass iteration.
    function automatic logic [XLEN-1:0] special_result(input logic [4:0] code,
                                                       input logic [XLEN-1:0] a,
                                                       input logic [XLEN-1:0] b);
        logic quotient_op;
        quotient_op = (code == AC_DIV) || (code == AC_DIVU);
        if (b == '0)
            return quotient_op ? '1 : a;
        // Only signed overflow (-2^(XLEN-1) / -1) reaches here.
        return quotient_op ? {1'b1, {(XLEN-1){1'b0}}} : '0;
    endfunction

    // Re-apply operand signs and select the requested word.
    function automatic logic [XLEN-1:0] fix_result(input logic div_op,
                                                   input logic hi_word,
                                                   input logic want_rem,
                                                   input logic neg_main,
                                                   input logic neg_rem,
                                                   input logic [XLEN-1:0] h,
                                                   input logic [XLEN-1:0] l);
        logic [2*XLEN-1:0] prod;
        if (div_op) begin
            if (want_rem)
                return neg_rem ? -h : h;
            return neg_main ? -l : l;
        end
        prod = {h, l};
        if (neg_main)
            prod = -prod;
        return hi_word ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    endfunction

    always_comb begin
        op_is_div = (op >= AC_DIV);
        sa_signed = (op == AC_MULH) || (op == AC_MULHSU) || (op == AC_DIV) || (op == AC_REM);
        sb_signed = (op == AC_MULH) || (op == AC_DIV) || (op == AC_REM);
        sign_a    = sa_signed && src_a[XLEN-1];
        sign_b    = sb_signed && src_b[XLEN-1];
        mag_a     = sign_a ? -src_a : src_a;
        mag_b     = sign_b ? -src_b : src_b;
    end

    // One iteration of either algorithm.
    always_comb begin
        sum     = {1'b0, hi} + ({1'b0, mcand} & {(XLEN+1){lo[0]}});
        shifted = {hi, lo[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, mcand};
        hi_n    = hi;
        lo_n    = lo;
        if (is_div_q) begin
            // Keep the subtraction only when it did not go negative.
            if (!diff[XLEN+1]) begin
                hi_n = diff[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_n = shifted[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi         <= '0;
            lo         <= '0;
            mcand      <= '0;
            result_q   <= '0;
            is_div_q   <= 1'b0;
            hi_word_q  <= 1'b0;
            want_rem_q <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else if (load) begin
            hi         <= '0;
            lo         <= op_is_div ? mag_a : mag_b;
            mcand      <= op_is_div ? mag_b : mag_a;
            is_div_q   <= op_is_div;
            hi_word_q  <= (op != AC_MUL);
            want_rem_q <= (op == AC_REM) || (op == AC_REMU);
            neg_q      <= sign_a ^ sign_b;
            neg_r      <= sign_a;
        end else if (fast_load) begin
            lo <= special_result(op, src_a, src_b);
        end else if (step) begin
            hi <= hi_n;
            lo <= lo_n;
            if (last)
                result_q <= fix_result(is_div_q, hi_word_q, want_rem_q, neg_q, neg_r, hi_n, lo_n);
        end else if (commit) begin
            result_q <= lo;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/muldiv_unit_e.sv
// ---------------------------------------------------------------------------
// muldiv_unit_e
// Iterative RV32M multiply/divide unit in the execute stage. Normal ops take
// ITER iteration cycles; divide-by-zero and signed overflow finish in two.
// The pipeline is held with stall_md while the unit is busy; done_md pulses
// for one cycle with the result on result_md.
//
// Ports:
//   clk              pipeline clock
//   reset            asynchronous, active-high reset
//   start_e          E-stage instruction valid and is an M-extension op
//   arith_control_e  operation code
//   src_a_e, src_b_e forwarded rs1 / rs2 values
//   flush_e          squash the E-stage instruction
//   stall_md         hold F/D/E, bubble M (combinational)
//   done_md          result valid this cycle
//   result_md        mul/div result (held between operations)
// ---------------------------------------------------------------------------
module muldiv_unit_e #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_e,
    input  logic [4:0]      arith_control_e,
    input  logic [XLEN-1:0] src_a_e,
    input  logic [XLEN-1:0] src_b_e,
    input  logic            flush_e,
    output logic            stall_md,
    output logic            done_md,
    output logic [XLEN-1:0] result_md
);
    import riscv_pkg::*;

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_t       state, state_next;
    logic [CW-1:0]   count;
    logic            accept, is_div, signed_div, special, last_step;
    logic            dp_load, dp_fast, dp_step, dp_commit;

    assign is_div     = (arith_control_e >= AC_DIV);
    assign signed_div = (arith_control_e == AC_DIV) || (arith_control_e == AC_REM);
    assign special    = is_div && ((src_b_e == '0) ||
                        (signed_div && (src_a_e == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_e == '1)));
    // Reset and flush both suppress acceptance so the outputs fall at once.
    assign accept     = (state == IDLE) && start_e && is_md_op(arith_control_e) &&
                        !flush_e && !reset;
    assign last_step  = (count == CW'(ITER - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (accept)
                count <= '0;
            else if (state == CALC)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        stall_md   = 1'b0;
        done_md    = 1'b0;
        dp_load    = 1'b0;
        dp_fast    = 1'b0;
        dp_step    = 1'b0;
        dp_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall_md   = 1'b1;
                    dp_load    = !special;
                    dp_fast    = special;
                    state_next = special ? FAST : CALC;
                end
            end
            CALC: begin
                stall_md = 1'b1;
                dp_step  = 1'b1;
                if (last_step)
                    state_next = DONE;
            end
            FAST: begin
                stall_md   = 1'b1;
                dp_commit  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                // The finishing instruction is still in E; start_e is ignored.
                done_md    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush_e) begin
            state_next = IDLE;
            stall_md   = 1'b0;
            done_md    = 1'b0;
            dp_step    = 1'b0;
            dp_commit  = 1'b0;
        end
    end

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (dp_load),
        .fast_load (dp_fast),
        .step      (dp_step),
        .last      (last_step),
        .commit    (dp_commit),
        .op        (arith_control_e),
        .src_a     (src_a_e),
        .src_b     (src_b_e),
        .result    (result_md)
    );

endmodule

// File: tb/tb_muldiv_unit_e.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit_e
// Self-checking bench for muldiv_unit_e. Expected results come from plain
// 64-bit arithmetic; expected stall/done timing comes from the documented
// latencies. Outputs are compared on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_muldiv_unit_e;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_e = 1'b0;
    logic        flush_e = 1'b0;
    logic [4:0]  arith_control_e = 5'd0;
    logic [31:0] src_a_e = 32'd0;
    logic [31:0] src_b_e = 32'd0;
    logic        stall_md, done_md;
    logic [31:0] result_md;

    int          n_checks = 0;
    int          n_pass = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0;
    logic        exp_done = 1'b0;
    logic [31:0] exp_result = 32'd0;

    muldiv_unit_e #(
        .XLEN (32),
        .ITER (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_e         (start_e),
        .arith_control_e (arith_control_e),
        .src_a_e         (src_a_e),
        .src_b_e         (src_b_e),
        .flush_e         (flush_e),
        .stall_md        (stall_md),
        .done_md         (done_md),
        .result_md       (result_md)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    endtask

    // Reference model: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (op)
            AC_MUL:    begin p = ua * ub;           return p[31:0];  end
            AC_MULH:   begin p = sa * sb;           return p[63:32]; end
            AC_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            AC_MULHU:  begin p = ua * ub;           return p[63:32]; end
            AC_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf)        return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            AC_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            AC_REM: begin
                if (b == 32'd0) return a;
                if (ovf)        return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            AC_REMU: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Cycle (relative to the accepting cycle 0) in which done_md is expected.
    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic div_type, signed_div;
        div_type   = (op == AC_DIV) || (op == AC_DIVU) || (op == AC_REM) || (op == AC_REMU);
        signed_div = (op == AC_DIV) || (op == AC_REM);
        if (div_type && (b == 32'd0)) return 2;
        if (signed_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 2;
        return 33;
    endfunction

    // Single compare process: every cycle while checking is enabled.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall_md", {31'd0, stall_md}, {31'd0, exp_stall});
            check("done_md", {31'd0, done_md}, {31'd0, exp_done});
            if (exp_done)
                check("result_md", result_md, exp_result);
        end
    end

    // All drivers run at posedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start_e   = 1'b0;
        exp_stall = 1'b0;
        exp_done  = 1'b0;
        repeat (n) tick();
    endtask

    // Present one op; start_e stays high through DONE as in the pipeline.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat             = ref_latency(op, a, b);
        exp_result      = ref_md(op, a, b);
        start_e         = 1'b1;
        arith_control_e = op;
        src_a_e         = a;
        src_b_e         = b;
        for (int k = 0; k <= lat; k++) begin
            exp_stall = (k < lat);
            exp_done  = (k == lat);
            tick();
        end
        start_e   = 1'b0;
        exp_stall = 1'b0;
        exp_done  = 1'b0;
    endtask

    // Pin the model to a hand-computed value, then run the DUT against it.
    task automatic pinned_op(input string name, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] lit, input int lat);
        check({name, "_model"}, ref_md(op, a, b), lit);
        check({name, "_latency"}, 32'(ref_latency(op, a, b)), 32'(lat));
        run_op(op, a, b);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", {31'd0, stall_md}, 32'd0);
        check("reset_done", {31'd0, done_md}, 32'd0);
        check("reset_result", result_md, 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Directed cases with literal expectations
        pinned_op("mul_7x-3",     AC_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        pinned_op("mulhu_ff",     AC_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        pinned_op("mulh_ff",      AC_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
        pinned_op("mulhsu_ff",    AC_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        pinned_op("div_-7_2",     AC_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        pinned_op("rem_-7_2",     AC_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        pinned_op("divu_100_7",   AC_DIVU,   32'd100,        32'd7,         32'd14,        33);
        pinned_op("remu_100_7",   AC_REMU,   32'd100,        32'd7,         32'd2,         33);
        idle(1);
        pinned_op("divu_5_0",     AC_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 2);
        pinned_op("rem_5_0",      AC_REM,    32'd5,          32'd0,         32'd5,         2);
        pinned_op("div_ovf",      AC_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2);
        pinned_op("rem_ovf",      AC_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2);
        idle(2);

        // Non-M code is ignored
        start_e         = 1'b1;
        arith_control_e = 5'd3;
        src_a_e         = 32'd9;
        src_b_e         = 32'd4;
        exp_stall       = 1'b0;
        exp_done        = 1'b0;
        repeat (4) tick();
        idle(1);

        // Flush at cycle 10 of a DIV; a following op must be accepted at once
        start_e         = 1'b1;
        arith_control_e = AC_DIV;
        src_a_e         = 32'hFFFF_FFF9;
        src_b_e         = 32'd2;
        for (int k = 0; k < 10; k++) begin
            exp_stall = 1'b1;
            exp_done  = 1'b0;
            tick();
        end
        flush_e   = 1'b1;
        exp_stall = 1'b0;
        exp_done  = 1'b0;
        tick();
        flush_e = 1'b0;
        start_e = 1'b0;
        run_op(AC_DIVU, 32'd100, 32'd7);
        idle(2);

        // Asynchronous reset at cycle 15 of a MUL
        start_e         = 1'b1;
        arith_control_e = AC_MUL;
        src_a_e         = 32'd7;
        src_b_e         = 32'hFFFF_FFFD;
        for (int k = 0; k < 15; k++) begin
            exp_stall = 1'b1;
            exp_done  = 1'b0;
            tick();
        end
        chk_en  = 1'b0;
        start_e = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("midreset_stall", {31'd0, stall_md}, 32'd0);
        check("midreset_done", {31'd0, done_md}, 32'd0);
        check("midreset_result", result_md, 32'd0);
        tick();
        reset     = 1'b0;
        exp_stall = 1'b0;
        exp_done  = 1'b0;
        chk_en    = 1'b1;
        idle(40);

        // Randomized ops, including back-to-back issue
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = AC_MUL + 5'($urandom_range(0, 7));
            a  = rnd_operand();
            b  = rnd_operand();
            run_op(op, a, b);
            if ($urandom_range(0, 2) == 0)
                idle($urandom_range(1, 3));
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
